// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the execute-stage divider sequencer: state
// encodings, handshake constants and default widths.
package div_ctrl_pkg;

    // Default operand width and iteration counter width (counter must hold DIV_WIDTH)
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    // Sequencer states
    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    // Request / handshake levels
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring-division iteration: trial-subtract the divisor from the
// shifted partial remainder and keep the difference only if it did not borrow.
module div_ctrl_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   part_i,     // {partial remainder, next dividend bit}
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,      // next partial remainder
    output logic             qbit_o      // quotient bit produced by this step
);

    logic [WIDTH:0] diff;

    // part_i < 2*divisor always holds, so a non-borrowing difference fits in WIDTH bits
    always_comb begin
        diff   = part_i - {1'b0, divisor_i};
        qbit_o = ~diff[WIDTH];
        rem_o  = diff[WIDTH] ? part_i[WIDTH-1:0] : diff[WIDTH-1:0];
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider sequencer for DIV/DIVU into HI/LO.
// result_o = {remainder, quotient}. Build option: DIV_EARLY_OUT_EN lets a
// divide whose |dividend| < |divisor| bypass the iteration entirely.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    div_state_e         state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;   // shifts out dividend, shifts in quotient
    logic [WIDTH-1:0]   divisor_q,  divisor_d;
    logic [WIDTH-1:0]   rem_q,      rem_d;        // partial remainder
    logic               neg_quo_q,  neg_quo_d;
    logic               neg_rem_q,  neg_rem_d;
    logic [2*WIDTH-1:0] result_q,   result_d;
    logic               ready_q,    ready_d;

    logic [WIDTH-1:0]   abs1, abs2;
    logic               sign1, sign2;
    logic               early_hit;
    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Operand magnitudes; signs only matter for DIV
    always_comb begin
        sign1 = signed_div_i & opdata1_i[WIDTH-1];
        sign2 = signed_div_i & opdata2_i[WIDTH-1];
        abs1  = sign1 ? (~opdata1_i + 1'b1) : opdata1_i;
        abs2  = sign2 ? (~opdata2_i + 1'b1) : opdata2_i;
    end

`ifdef DIV_EARLY_OUT_EN
    assign early_hit = (abs1 < abs2);
`else
    assign early_hit = 1'b0;
`endif

    div_ctrl_step #(.WIDTH(WIDTH)) u_step (
        .part_i    ({rem_q, dividend_q[WIDTH-1]}),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // Final sign correction: quotient negative iff signs differ, remainder follows dividend
    always_comb begin
        quo_fix = neg_quo_q ? (~dividend_q + 1'b1) : dividend_q;
        rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        unique case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else if (early_hit) begin
                        // Quotient 0, remainder is the dividend exactly as presented
                        result_d = {opdata1_i, {WIDTH{1'b0}}};
                        state_d  = DIV_END;
                    end else begin
                        dividend_d = abs1;
                        divisor_d  = abs2;
                        rem_d      = '0;
                        cnt_d      = '0;
                        neg_quo_d  = sign1 ^ sign2;
                        neg_rem_d  = sign1;
                        state_d    = DIV_ON;
                    end
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    result_d = '0;
                    state_d  = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (cnt_q < CNT_W'(WIDTH)) begin
                    rem_d      = step_rem;
                    dividend_d = {dividend_q[WIDTH-2:0], step_qbit};
                    cnt_d      = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DIV_RESULT_READY;
                    state_d  = DIV_END;
                end
            end
            DIV_END: begin
                // Paths that reach END without raising ready do so on the first END cycle
                if (annul_i || start_i == DIV_STOP) begin
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                    state_d  = DIV_FREE;
                end else begin
                    ready_d = DIV_RESULT_READY;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: vector table of divides plus hand-written
// annul, reset and start/annul-collision sequences.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, annul_i, signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic [63:0] result_o;
    logic        ready_o, stallreq_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (b == 32'd0) return 3;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 2;
`endif
        return 34;
    endfunction

    // Run one divide; counts edges until ready_o, checks latency, result and stall.
    // With hold set, start_i stays high and the DUT is left in END.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input string name, input bit hold);
        int  n;
        bit  stall_ok;
        @(negedge clk);
        signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        #1;
        check({name, " stall_at_start"}, 64'(stallreq_o), 64'd1);
        n = 0;
        stall_ok = 1'b1;
        forever begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                // operands must be ignored once the divide is under way
                opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sgn;
            end
            if (ready_o) break;
            if (!stallreq_o) stall_ok = 1'b0;
            if (n >= 100) break;
        end
        $display("div %s sgn=%0d 0x%08h/0x%08h -> 0x%016h after %0d edges", name, sgn, a, b, result_o, n);
        check({name, " latency"}, 64'(n), 64'(exp_lat(sgn, a, b)));
        check({name, " result"}, result_o, exp);
        check({name, " stall_while_busy"}, 64'(stall_ok), 64'd1);
        check({name, " stall_at_ready"}, 64'(stallreq_o), 64'd0);
        if (!hold) begin
            @(negedge clk); start_i = 1'b0;
            @(posedge clk); #1;
            check({name, " ready_drop"}, 64'(ready_o), 64'd0);
            check({name, " result_clear"}, result_o, 64'd0);
        end
    endtask

    initial begin
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, "divu_100_7"};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, "div_m7_2"};
        vecs[2]  = '{1'b0, 32'd5,          32'd0,          64'h00000000_00000000, "divu_5_0"};
        vecs[3]  = '{1'b0, 32'd3,          32'd10,         64'h00000003_00000000, "divu_3_10"};
        vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, "div_min_m1"};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, "divu_max_1"};
        vecs[6]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   64'h00000002_FFFFFFF2, "div_100_m7"};
        vecs[7]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, "divu_big_2"};
        vecs[8]  = '{1'b1, 32'hFFFFFFF9,   32'd100,        64'hFFFFFFF9_00000000, "div_m7_100"};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, "div_m100_m7"};
        vecs[10] = '{1'b0, 32'd0,          32'd5,          64'h00000000_00000000, "divu_0_5"};
        vecs[11] = '{1'b0, 32'h12345678,   32'h00001000,   64'h00000678_00012345, "divu_hex_4k"};
        vecs[12] = '{1'b1, 32'd5,          32'd0,          64'h00000000_00000000, "div_5_0"};

        // Reset state
        #12;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < 13; i++)
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 1'b0);

        // start and annul together in FREE: annul wins, nothing starts
        @(negedge clk);
        opdata1_i = 32'd9; opdata2_i = 32'd0; signed_div_i = 1'b0;
        start_i = 1'b1; annul_i = 1'b1;
        #1;
        check("collide_stall", 64'(stallreq_o), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("collide_ready", 64'(ready_o), 64'd0);
        @(negedge clk); start_i = 1'b0; annul_i = 1'b0;
        $display("seq start+annul collision done");

        // annul on edge 10 of 100/7, then the divide must never complete
        begin
            bit saw_ready;
            @(negedge clk);
            opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
            repeat (9) @(posedge clk);
            @(negedge clk); annul_i = 1'b1;
            #1;
            check("annul_stall", 64'(stallreq_o), 64'd0);
            @(posedge clk); #1;
            annul_i = 1'b0; start_i = 1'b0;
            saw_ready = 1'b0;
            repeat (40) begin
                @(posedge clk); #1;
                if (ready_o) saw_ready = 1'b1;
            end
            check("annul_no_ready", 64'(saw_ready), 64'd0);
            $display("seq annul at edge 10 done");
        end
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, "after_annul", 1'b0);

        // asynchronous reset at edge 20 of a divide
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (20) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_ready", 64'(ready_o), 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        @(negedge clk); start_i = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("rst_mid_idle_ready", 64'(ready_o), 64'd0);
        $display("seq reset mid-divide done");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "after_rst", 1'b1);

        // asynchronous reset while holding a completed result
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_end_ready", 64'(ready_o), 64'd0);
        check("rst_end_result", result_o, 64'd0);
        @(negedge clk); start_i = 1'b0;
        @(negedge clk); rst = 1'b1;
        $display("seq reset in END done");

        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "final_100_7", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle sequencer for the shared 32-bit restoring divider feeding HI/LO in the execute stage.
- Accepts a DIV/DIVU request, stalls the pipeline while iterating, and delivers {remainder, quotient} for the HI/LO write.
- Handles signed correction, divide-by-zero and annulment when the instruction is flushed, for example by a taken-branch squash.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  divide request, held high by EX until ready_o is seen.
- annul_i  in  1  abort current or pending divide (pipeline flush).
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- result_o  out  2*WIDTH  {remainder[HI], quotient[LO]}.
- ready_o  out  1  result valid.
- stallreq_o  out  1  pipeline stall request.

Behaviour:
- Reset (rst low, asynchronous):
  - State = FREE, counter = 0, internal dividend/divisor registers = 0.
  - result_o = 0, ready_o = 0.
- States and transitions:
  - FREE: if start_i & ~annul_i:
    - divisor == 0 -> BYZERO.
    - otherwise latch |op1| and |op2| (absolute value only when signed_div_i; raw otherwise), record the operand signs, counter = 0 -> ON.
    - Otherwise stay in FREE with ready_o = 0 and result_o = 0.
  - BYZERO: internal result = 0 -> END.
  - ON:
    - annul_i -> FREE; ready_o stays 0 and nothing is written.
    - counter < WIDTH: one restoring step per cycle (WIDTH+1-bit trial subtract, shift in quotient bit), counter++.
    - counter == WIDTH: apply sign fix, load result_o -> END.
  - END: ready_o = 1 and result_o holds its value while start_i stays high. When start_i falls -> FREE, clearing ready_o and result_o. annul_i in END also -> FREE.
- Sign correction (signed only):
  - Quotient is negated iff the dividend sign differs from the divisor sign.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wrap, no trap).
- Latency (count the edge that samples start_i as edge 1):
  - Normal divide: ON iterates on edges 2..WIDTH+1; result registered and ready_o high after edge WIDTH+2 (34 for WIDTH = 32).
  - Divide-by-zero: ready_o high after edge 3.
- stallreq_o = start_i & ~ready_o & ~annul_i (combinational). Stall drops in the same cycle ready_o rises.
- Operands are sampled only on the FREE->ON edge. Later changes on opdata*_i are ignored until the next FREE.
- Simultaneous start_i and annul_i in FREE: annul wins, no transition.
- Reset mid-operation: immediate return to the reset state; the next start runs from scratch.

Optional Feature:
- DIV_EARLY_OUT_EN defined:
  - In FREE, if |dividend| < |divisor| (unsigned compare after abs), skip ON and go directly to END.
  - Quotient = 0, remainder = dividend (signed form preserved); ready_o high after edge 2.
- Not defined: every nonzero-divisor divide takes the full WIDTH+2 edges.

Decomposition:
- Shared package/defines header holds:
  - State encodings DIV_FREE=2'b00, DIV_BYZERO=2'b01, DIV_ON=2'b10, DIV_END=2'b11.
  - DIV_START/DIV_STOP and DIV_RESULT_READY/NOT_READY constants.
  - Width macros.
- Sub-module div_step (combinational): one restoring iteration. Takes the partial remainder and the divisor, returns the next partial remainder and the quotient bit.

Test Plan:
- DIVU 100/7: ready after 34 edges; result_o = 0x00000002_0000000E; stallreq_o high for cycles 1-33, then low.
- DIV -7/2 (0xFFFFFFF9 / 0x00000002): result_o = 0xFFFFFFFF_FFFFFFFD.
- Divide by zero, 5/0: ready after 3 edges; result_o = 0. Then drop start_i: ready_o = 0 next cycle.
- annul_i pulsed on edge 10 of 100/7: state FREE, ready_o never rises. Immediate restart 0xFFFFFFFF/1 unsigned gives 0x00000000_FFFFFFFF after 34 edges.
- rst low at edge 20 of a divide: ready_o/result_o = 0 asynchronously. After release, 0x80000000/0xFFFFFFFF signed gives 0x00000000_80000000.
- With DIV_EARLY_OUT_EN, DIVU 3/10: ready after 2 edges, result_o = 0x00000003_00000000. Without it, the same result after 34 edges.
